reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file_pkg.sv | 6 +
 rtl/reg_file.sv | 55 +++++
 tb/tb_reg_file.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared CPU datapath widths used by the register file, ALU, mux and control
package reg_file_pkg;
  localparam int REG_DATA_W = 8;
  localparam int REG_ADDR_W = 3;
  localparam int REG_COUNT  = 1 << REG_ADDR_W;
endpackage

// File: rtl/reg_file.sv
// rtl/reg_file.sv - two-read one-write register file with hard-wired r0 and write-to-read bypass
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   reg_write,
  input  logic [ADDR_W-1:0]      write_addr,
  input  logic [DATA_W-1:0]      write_data,
  input  logic [ADDR_W-1:0]      read_addr_a,
  input  logic [ADDR_W-1:0]      read_addr_b,
  output logic [DATA_W-1:0]      read_data_a,
  output logic [DATA_W-1:0]      read_data_b,
  output logic [(1<<ADDR_W)-1:0] reg_valid
);

  localparam int NUM_REGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              write_en;

  // r0 is never written, so a write aimed at it must neither store nor bypass
  assign write_en = !rst && reg_write && (write_addr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      reg_valid <= '0;
    end else if (write_en) begin
      regs[write_addr]      <= write_data;
      reg_valid[write_addr] <= 1'b1;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    if (addr == '0) begin
      return '0;
    end
    if (write_en && (addr == write_addr)) begin
      return write_data;
    end
    return regs[addr];
  endfunction

  always_comb begin
    read_data_a = read_port(read_addr_a);
    read_data_b = read_port(read_addr_b);
  end

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - scoreboard bench for reg_file reads, bypass, r0 and reset behaviour
module tb_reg_file;

  logic       clk = 1'b0;
  logic       rst;
  logic       reg_write;
  logic [2:0] write_addr;
  logic [7:0] write_data;
  logic [2:0] read_addr_a;
  logic [2:0] read_addr_b;
  logic [7:0] read_data_a;
  logic [7:0] read_data_b;
  logic [7:0] reg_valid;

  typedef struct {
    string      tag;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    logic [7:0] exp_valid;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] model_mem [8];
  logic [7:0] model_valid;
  int         n_checks = 0;
  int         n_fail   = 0;

  reg_file dut (
    .clk         (clk),
    .rst         (rst),
    .reg_write   (reg_write),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .read_addr_a (read_addr_a),
    .read_addr_b (read_addr_b),
    .read_data_a (read_data_a),
    .read_data_b (read_data_b),
    .reg_valid   (reg_valid)
  );

  always #5 clk = ~clk;

  // reference state, advanced on the same edge as the design
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) model_mem[i] = 8'h00;
      model_valid = 8'h00;
    end else if (reg_write && write_addr != 3'd0) begin
      model_mem[write_addr]   = write_data;
      model_valid[write_addr] = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [2:0] addr);
    if (addr == 3'd0) return 8'h00;
    if (!rst && reg_write && write_addr != 3'd0 && write_addr == addr) return write_data;
    return model_mem[addr];
  endfunction

  // drives one cycle at the falling edge, queues the expectation, then checks just after
  task automatic step(input string tag, input logic r, input logic we, input logic [2:0] wa,
                      input logic [7:0] wd, input logic [2:0] ra, input logic [2:0] rb);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst = r; reg_write = we; write_addr = wa; write_data = wd;
    read_addr_a = ra; read_addr_b = rb;
    #1;
    e.tag = tag;
    e.exp_a = model_read(ra);
    e.exp_b = model_read(rb);
    e.exp_valid = model_valid;
    sb_q.push_back(e);
    #1;
    got = sb_q.pop_front();
    check({got.tag, ".a"}, read_data_a, got.exp_a);
    check({got.tag, ".b"}, read_data_b, got.exp_b);
    check({got.tag, ".valid"}, reg_valid, got.exp_valid);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) model_mem[i] = 8'h00;
    model_valid = 8'h00;
    rst = 1'b1; reg_write = 1'b0; write_addr = 3'd0; write_data = 8'h00;
    read_addr_a = 3'd0; read_addr_b = 3'd0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 8; i++) begin
      step("reset_read", 1'b0, 1'b0, 3'd0, 8'h00, 3'(i), 3'(7 - i));
      check("reset_read_a_const", read_data_a, 8'h00);
      check("reset_read_b_const", read_data_b, 8'h00);
    end
    check("reset_valid_const", reg_valid, 8'h00);

    step("wr_r3", 1'b0, 1'b1, 3'd3, 8'hA5, 3'd0, 3'd0);
    step("rd_r3", 1'b0, 1'b0, 3'd6, 8'h5A, 3'd3, 3'd1);
    check("r3_const", read_data_a, 8'hA5);
    check("r3_valid_const", reg_valid, 8'h08);

    step("bypass_r5", 1'b0, 1'b1, 3'd5, 8'h3C, 3'd5, 3'd5);
    check("bypass_a_const", read_data_a, 8'h3C);
    check("bypass_b_const", read_data_b, 8'h3C);
    step("stored_r5", 1'b0, 1'b0, 3'd0, 8'h00, 3'd5, 3'd5);
    check("stored_r5_const", read_data_b, 8'h3C);

    step("wr_r0", 1'b0, 1'b1, 3'd0, 8'hFF, 3'd0, 3'd0);
    check("r0_same_cycle_const", read_data_a, 8'h00);
    step("rd_r0", 1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
    check("r0_after_const", read_data_b, 8'h00);
    check("r0_valid_bit", {7'd0, reg_valid[0]}, 8'h00);

    step("wr_r2", 1'b0, 1'b1, 3'd2, 8'h11, 3'd2, 3'd0);
    step("rst_vs_write", 1'b1, 1'b1, 3'd2, 8'h77, 3'd2, 3'd2);
    check("rst_no_bypass_const", read_data_a, 8'h11);
    step("after_rst", 1'b0, 1'b0, 3'd0, 8'h00, 3'd2, 3'd2);
    check("r2_cleared_const", read_data_a, 8'h00);
    check("rst_valid_const", reg_valid, 8'h00);

    for (int i = 1; i < 8; i++) step("fill", 1'b0, 1'b1, 3'(i), 8'(i), 3'(i), 3'(i - 1));
    for (int i = 0; i < 10; i++)
      step("no_write", 1'b0, 1'b0, 3'($urandom_range(0, 7)), 8'($urandom),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    for (int i = 0; i < 8; i++) begin
      step("hold_read", 1'b0, 1'b0, 3'(i), 8'hEE, 3'(i), 3'(i));
      check("hold_const", read_data_a, 8'(i));
    end
    check("hold_valid_const", reg_valid, 8'hFE);

    for (int i = 0; i < 60; i++)
      step("random", ($urandom_range(0, 15) == 0), 1'($urandom), 3'($urandom_range(0, 7)),
           8'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));

    check("sb_empty", 8'(sb_q.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
